// File: rtl/md_stall_ctrl.sv
// Multiply/divide launch scheduler and D-stage stall controller.
// Optional macro MD_EARLY_RELEASE_EN releases D one cycle early (MDU forwards on md_done).
module md_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_D,
  input  logic [31:0]      IR_E,
  input  logic             Req_exc,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic             md_done,
  output logic             Stall_D
);

  localparam logic [5:0]       OP_SPECIAL = 6'b000000;
  localparam logic [3:0]       FN_MD      = 4'b0110;
  localparam logic [3:0]       FN_HILO    = 4'b0100;
  localparam logic [CNT_W-1:0] MULT_LD    = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD     = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_start_e;
  logic             w_start_e_valid;
  logic             w_hilo_d;
  logic             w_busy_term;
  logic             w_unused;

  // funct 0110xx = mult/multu/div/divu, 0100xx = mfhi/mthi/mflo/mtlo
  assign w_start_e = (IR_E[31:26] == OP_SPECIAL) && (IR_E[5:2] == FN_MD);
  assign w_hilo_d  = (IR_D[31:26] == OP_SPECIAL) &&
                     ((IR_D[5:2] == FN_MD) || (IR_D[5:2] == FN_HILO));

  assign w_start_e_valid = w_start_e && !Req_exc;
  assign md_start        = w_start_e_valid && !r_busy;
  assign md_op           = IR_E[1:0];

`ifdef MD_EARLY_RELEASE_EN
  assign w_busy_term = (r_cnt > CNT_ONE);
`else
  assign w_busy_term = r_busy;
`endif

  assign Stall_D = w_hilo_d && (w_busy_term || w_start_e_valid);

  // Load on launch (funct bit 1 selects divide), otherwise count down to zero
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (md_start) begin
      w_cnt_nxt = IR_E[1] ? DIV_LD : MULT_LD;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_done <= (r_cnt == CNT_ONE);
    end
  end

  assign md_cnt  = r_cnt;
  assign md_busy = r_busy;
  assign md_done = r_done;

  assign w_unused = ^{IR_D[25:6], IR_E[25:6]};

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed self-checking bench for md_stall_ctrl (mult/div launch, stall, exception, async reset).
module tb_md_stall_ctrl;

  localparam logic [31:0] I_MULT = 32'h0109_0018;
  localparam logic [31:0] I_DIV  = 32'h0109_001A;
  localparam logic [31:0] I_DIVU = 32'h0109_001B;
  localparam logic [31:0] I_MFLO = 32'h0000_1012;
  localparam logic [31:0] I_MFHI = 32'h0000_1010;
  localparam logic [31:0] I_MTLO = 32'h0100_0013;
  localparam logic [31:0] I_ADDU = 32'h0109_5021;
  localparam logic [31:0] I_LWX  = 32'h8D09_0018;
`ifdef MD_EARLY_RELEASE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D;
  logic [31:0] IR_E;
  logic        Req_exc;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic        md_done;
  logic        Stall_D;

  int n_assert = 0;
  int n_fail   = 0;

  md_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .Req_exc(Req_exc),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_cnt(md_cnt),
    .md_done(md_done), .Stall_D(Stall_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; IR_D = '0; IR_E = '0; Req_exc = 1'b0;
    #3;
    chk("rst_cnt",   32'(md_cnt),   32'(0));
    chk("rst_busy",  32'(md_busy),  32'(0));
    chk("rst_done",  32'(md_done),  32'(0));
    chk("rst_start", 32'(md_start), 32'(0));
    chk("rst_stall", 32'(Stall_D),  32'(0));
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // Non-special opcode with an MDU-like funct is not a start
    IR_E = I_LWX; IR_D = I_MFLO; #2;
    chk("lwx_start", 32'(md_start), 32'(0));
    chk("lwx_stall", 32'(Stall_D),  32'(0));
    tick(); IR_E = '0; IR_D = '0;
    tick();

    // mult in E, mflo in D
    IR_E = I_MULT; IR_D = I_MFLO; #2;
    chk("mul_start", 32'(md_start), 32'(1));
    chk("mul_op",    32'(md_op),    32'(0));
    chk("mul_stall0", 32'(Stall_D), 32'(1));
    tick(); IR_E = '0;
    for (int j = 1; j <= 5; j++) begin
      #2;
      chk("mul_cnt",   32'(md_cnt),  32'(6 - j));
      chk("mul_busy",  32'(md_busy), 32'(1));
      chk("mul_done0", 32'(md_done), 32'(0));
      chk("mul_stall", 32'(Stall_D), (EARLY && j == 5) ? 32'(0) : 32'(1));
      tick();
      if (EARLY && j == 5) begin IR_E = I_MFLO; IR_D = '0; end
    end
    #2;
    chk("mul_done",   32'(md_done),  32'(1));
    chk("mul_cnt0",   32'(md_cnt),   32'(0));
    chk("mul_busy0",  32'(md_busy),  32'(0));
    chk("mul_rel",    32'(Stall_D),  32'(0));
    chk("mul_nostart", 32'(md_start), 32'(0));
    tick();
    IR_E = EARLY ? '0 : I_MFLO; IR_D = '0; #2;
    chk("mul_done_pulse", 32'(md_done), 32'(0));
    chk("mul_stall_end",  32'(Stall_D), 32'(0));
    tick(); IR_E = '0;

    // divu cancelled by exception
    IR_E = I_DIVU; IR_D = I_MFHI; Req_exc = 1'b1; #2;
    chk("exc_start", 32'(md_start), 32'(0));
    chk("exc_stall", 32'(Stall_D),  32'(0));
    tick(); Req_exc = 1'b0; IR_E = '0; IR_D = '0; #2;
    chk("exc_cnt",  32'(md_cnt),  32'(0));
    chk("exc_busy", 32'(md_busy), 32'(0));
    tick();

    // div with exception pulse mid-operation; non-HI/LO D never stalls
    IR_E = I_DIV; IR_D = I_ADDU; #2;
    chk("div_start", 32'(md_start), 32'(1));
    chk("div_op",    32'(md_op),    32'(2));
    chk("div_nostall", 32'(Stall_D), 32'(0));
    tick(); IR_E = '0;
    for (int j = 1; j <= 10; j++) begin
      Req_exc = (j == 7);
      IR_D = (j == 2) ? I_MTLO : I_ADDU;
      #2;
      chk("div_cnt",   32'(md_cnt),  32'(11 - j));
      chk("div_busy",  32'(md_busy), 32'(1));
      chk("div_done0", 32'(md_done), 32'(0));
      chk("div_stall", 32'(Stall_D), (j == 2) ? 32'(1) : 32'(0));
      tick();
    end
    Req_exc = 1'b0; IR_D = '0; #2;
    chk("div_done",  32'(md_done), 32'(1));
    chk("div_cnt0",  32'(md_cnt),  32'(0));
    chk("div_busy0", 32'(md_busy), 32'(0));
    tick(); #2;
    chk("div_done_pulse", 32'(md_done), 32'(0));
    tick();

    // mult followed immediately by div
    IR_E = I_MULT; IR_D = I_DIV; #2;
    chk("b2b_start0", 32'(md_start), 32'(1));
    chk("b2b_op0",    32'(md_op),    32'(0));
    chk("b2b_stall0", 32'(Stall_D),  32'(1));
    tick(); IR_E = '0;
    for (int j = 1; j <= 5; j++) begin
      #2;
      chk("b2b_cnt",   32'(md_cnt),   32'(6 - j));
      chk("b2b_stall", 32'(Stall_D),  (EARLY && j == 5) ? 32'(0) : 32'(1));
      chk("b2b_idle",  32'(md_start), 32'(0));
      tick();
    end
    IR_E = I_DIV; IR_D = I_MFLO; #2;
    chk("b2b_start1", 32'(md_start), 32'(1));
    chk("b2b_op1",    32'(md_op),    32'(2));
    chk("b2b_stall1", 32'(Stall_D),  32'(1));
    tick(); IR_E = '0; #2;
    chk("b2b_cnt10", 32'(md_cnt),  32'(10));
    chk("b2b_busy",  32'(md_busy), 32'(1));
    chk("b2b_hold",  32'(Stall_D), 32'(1));
    tick(); tick(); tick(); #2;
    chk("pre_rst_cnt", 32'(md_cnt), 32'(7));

    // Asynchronous reset mid-divide
    reset = 1'b0; #1;
    chk("arst_cnt",   32'(md_cnt),  32'(0));
    chk("arst_busy",  32'(md_busy), 32'(0));
    chk("arst_stall", 32'(Stall_D), 32'(0));
    chk("arst_done",  32'(md_done), 32'(0));
    tick(); tick();
    reset = 1'b1; IR_D = '0;
    for (int j = 0; j < 12; j++) begin
      #2;
      chk("arst_nodone", 32'(md_done), 32'(0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
